// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types and constants for the pipeline
// stall/flush sequencer (FSM state encoding, hazard stall lengths).
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HAZ_STALL = 2'd1,
    MD_WAIT   = 2'd2
  } state_t;

  localparam logic [1:0] HAZ_LEN_1 = 2'd1;
  localparam logic [1:0] HAZ_LEN_2 = 2'd2;

endpackage

// File: rtl/perf_sat_counter.sv
// perf_sat_counter: saturating event counter, clears on async rst.
// Ports: clk, rst, inc (count this cycle), count (CNT_W value).
module perf_sat_counter
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && !(&r_count)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Inputs: haz_req/haz_len, mispredict, md_req/md_done, dmem_req/
//   dmem_ready, imem_ready, trap_req. Outputs: per-stage enables,
//   flush/bubble controls, md_go, md_kill, trap_ack.
// Macro PIPE_PERF_CNT_EN adds stall_cnt/flush_cnt (CNT_W bits).
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             haz_req,
  input  logic [1:0]       haz_len,
  input  logic             mispredict,
  input  logic             md_req,
  input  logic             md_done,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             imem_ready,
  input  logic             trap_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             mem_wb_bubble,
  output logic             md_go,
  output logic             md_kill,
  output logic             trap_ack
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  state_t     r_state;
  state_t     w_state_n;
  logic [1:0] r_cnt;
  logic [1:0] w_cnt_n;
  logic       r_md_done_q;
  logic       w_md_done_q_n;
  logic       w_mem_stall;
  logic       w_stalled;
  logic       w_redirect;

  assign w_mem_stall = dmem_req & ~dmem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_cnt       <= '0;
      r_md_done_q <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_md_done_q <= w_md_done_q_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_md_done_q_n = r_md_done_q;
    w_stalled     = 1'b0;
    w_redirect    = 1'b0;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    md_go         = 1'b0;
    md_kill       = 1'b0;
    trap_ack      = 1'b0;

    if (w_mem_stall) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
      w_stalled     = 1'b1;
      // Remember a result that lands while MEM holds the pipe.
      if (r_state == MD_WAIT && md_done) begin
        w_md_done_q_n = 1'b1;
      end
    end else if (trap_req) begin
      trap_ack      = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      w_redirect    = 1'b1;
      md_kill       = (r_state == MD_WAIT);
      w_state_n     = RUN;
      w_cnt_n       = '0;
      w_md_done_q_n = 1'b0;
    end else if (r_state == MD_WAIT) begin
      if (md_done || r_md_done_q) begin
        w_state_n     = RUN;
        w_md_done_q_n = 1'b0;
      end else begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_bubble = 1'b1;
        w_stalled     = 1'b1;
      end
    end else if (r_state == RUN && md_req) begin
      md_go         = 1'b1;
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_bubble = 1'b1;
      w_stalled     = 1'b1;
      w_state_n     = MD_WAIT;
      w_md_done_q_n = 1'b0;
    end else if (r_state == HAZ_STALL) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
      w_stalled    = 1'b1;
      if (r_cnt <= 2'd1) begin
        w_state_n = RUN;
        w_cnt_n   = '0;
      end else begin
        w_cnt_n = r_cnt - 2'd1;
      end
    end else if (r_state != RUN) begin
      // Unused encoding: fall back to RUN.
      w_state_n = RUN;
      w_cnt_n   = '0;
    end else if (haz_req && haz_len != 2'd0) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
      w_stalled    = 1'b1;
      // Length 3 is not a legal request; it is treated as 2.
      if (haz_len != HAZ_LEN_1) begin
        w_state_n = HAZ_STALL;
        w_cnt_n   = HAZ_LEN_2 - HAZ_LEN_1;
      end
    end else if (mispredict) begin
      if_id_flush = 1'b1;
      w_redirect  = 1'b1;
    end

    // Fetch miss: bubble IF/ID, but a redirect still loads the PC.
    if (!imem_ready && !w_stalled) begin
      if_id_flush = 1'b1;
      if (!w_redirect) begin
        pc_en = 1'b0;
      end
    end

    if (rst) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_en     = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      mem_wb_bubble = 1'b1;
      md_go         = 1'b0;
      md_kill       = 1'b0;
      trap_ack      = 1'b0;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_stall_inc = ~rst & ~pc_en;
  assign w_flush_inc = ~rst & w_redirect;

  perf_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  perf_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_flush_inc),
    .count (flush_cnt)
  );
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_pipeline_ctrl;

  localparam int CNT_W = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       haz_req = 1'b0;
  logic [1:0] haz_len = 2'd0;
  logic       mispredict = 1'b0;
  logic       md_req = 1'b0;
  logic       md_done = 1'b0;
  logic       dmem_req = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       imem_ready = 1'b1;
  logic       trap_req = 1'b0;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_bubble, ex_mem_bubble;
  logic       mem_wb_bubble, md_go, md_kill, trap_ack;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .haz_req       (haz_req),
    .haz_len       (haz_len),
    .mispredict    (mispredict),
    .md_req        (md_req),
    .md_done       (md_done),
    .dmem_req      (dmem_req),
    .dmem_ready    (dmem_ready),
    .imem_ready    (imem_ready),
    .trap_req      (trap_req),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .id_ex_en      (id_ex_en),
    .ex_mem_en     (ex_mem_en),
    .mem_wb_en     (mem_wb_en),
    .if_id_flush   (if_id_flush),
    .id_ex_bubble  (id_ex_bubble),
    .ex_mem_bubble (ex_mem_bubble),
    .mem_wb_bubble (mem_wb_bubble),
    .md_go         (md_go),
    .md_kill       (md_kill),
    .trap_ack      (trap_ack)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  wire [11:0] outv = {pc_en, if_id_en, id_ex_en, ex_mem_en,
                      mem_wb_en, if_id_flush, id_ex_bubble,
                      ex_mem_bubble, mem_wb_bubble, md_go,
                      md_kill, trap_ack};

  localparam logic [11:0] RST_OUT  = 12'b00000_1111_000;
  localparam logic [11:0] IDLE_OUT = 12'b11111_0000_000;

  int errs = 0;
  int checks = 0;

  // Model: remaining extra hazard cycles, mul/div busy, result seen.
  int          m_haz = 0, n_haz = 0;
  bit          m_md = 0, n_md = 0;
  bit          m_pend = 0, n_pend = 0;
  longint      m_sc = 0, n_sc = 0, m_fc = 0, n_fc = 0;
  logic [11:0] e_out;

  task automatic model_eval;
    bit pe = 1, ie = 1, de = 1, xe = 1, we = 1;
    bit fl = 0, db = 0, xb = 0, wb = 0, go = 0, kl = 0, ak = 0;
    bit red = 0, stl = 0;
    longint sat = (64'd1 << CNT_W) - 1;
    n_haz = m_haz; n_md = m_md; n_pend = m_pend;
    if (rst) begin
      pe = 0; ie = 0; de = 0; xe = 0; we = 0;
      fl = 1; db = 1; xb = 1; wb = 1;
      n_haz = 0; n_md = 0; n_pend = 0;
      m_sc = 0; m_fc = 0;
    end else if (dmem_req && !dmem_ready) begin
      pe = 0; ie = 0; de = 0; xe = 0; wb = 1; stl = 1;
      if (m_md && md_done) n_pend = 1;
    end else if (trap_req) begin
      ak = 1; fl = 1; db = 1; xb = 1; red = 1; kl = m_md;
      n_md = 0; n_pend = 0; n_haz = 0;
    end else if (m_md) begin
      if (md_done || m_pend) begin
        n_md = 0; n_pend = 0;
      end else begin
        pe = 0; ie = 0; de = 0; xb = 1; stl = 1;
      end
    end else if (m_haz > 0) begin
      pe = 0; ie = 0; db = 1; stl = 1; n_haz = m_haz - 1;
    end else if (md_req) begin
      go = 1; pe = 0; ie = 0; de = 0; xb = 1; stl = 1; n_md = 1;
    end else if (haz_req && haz_len != 0) begin
      pe = 0; ie = 0; db = 1; stl = 1; n_haz = int'(haz_len) - 1;
    end else if (mispredict) begin
      fl = 1; red = 1;
    end
    if (!rst && !imem_ready && !stl) begin
      fl = 1;
      if (!red) pe = 0;
    end
    n_sc = m_sc; n_fc = m_fc;
    if (!rst && !pe && m_sc < sat) n_sc = m_sc + 1;
    if (!rst && red && m_fc < sat) n_fc = m_fc + 1;
    if (rst) begin n_sc = 0; n_fc = 0; end
    e_out = {pe, ie, de, xe, we, fl, db, xb, wb, go, kl, ak};
  endtask

  // One cycle: commit model at the edge just passed, drive, evaluate.
  task automatic apply(input bit r, hq, input bit [1:0] hl,
                       input bit mp, mq, md, dq, dr, ir, tr);
    @(negedge clk);
    m_haz = n_haz; m_md = n_md; m_pend = n_pend;
    m_sc = n_sc; m_fc = n_fc;
    rst = r; haz_req = hq; haz_len = hl; mispredict = mp;
    md_req = mq; md_done = md; dmem_req = dq; dmem_ready = dr;
    imem_ready = ir; trap_req = tr;
    #1;
    model_eval();
  endtask

  task automatic test_reset;
    apply(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (outv !== RST_OUT) begin
      errs++;
      $display("FAIL reset out=%b exp=%b", outv, RST_OUT);
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (outv !== IDLE_OUT) begin
      errs++;
      $display("FAIL reset_idle out=%b exp=%b", outv, IDLE_OUT);
    end
  endtask

  task automatic test_haz2;
    int lo = 0;
    apply(0, 1, 2, 0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (outv !== e_out || id_ex_bubble !== 1'b1) begin
      errs++;
      $display("FAIL haz2_c0 out=%b exp=%b", outv, e_out);
    end
    lo += (pc_en == 1'b0);
    for (int i = 1; i < 4; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (outv !== e_out) begin
        errs++;
        $display("FAIL haz2_c%0d out=%b exp=%b", i, outv, e_out);
      end
      lo += (pc_en == 1'b0);
      if (i == 1) begin
        checks++;
        if (id_ex_bubble !== 1'b1) begin
          errs++;
          $display("FAIL haz2_bub got=%b exp=1", id_ex_bubble);
        end
      end
    end
    checks++;
    if (lo != 2) begin
      errs++;
      $display("FAIL haz2_len got=%0d exp=2", lo);
    end
  endtask

  task automatic test_md;
    int gos = 0, bub = 0;
    apply(0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    gos += md_go; bub += ex_mem_bubble;
    for (int i = 1; i <= 4; i++) begin
      apply(0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
      gos += md_go; bub += ex_mem_bubble;
      checks++;
      if (outv !== e_out) begin
        errs++;
        $display("FAIL md_wait%0d out=%b exp=%b", i, outv, e_out);
      end
    end
    apply(0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    checks++;
    if (outv !== IDLE_OUT) begin
      errs++;
      $display("FAIL md_done out=%b exp=%b", outv, IDLE_OUT);
    end
    checks++;
    if (gos != 1 || bub != 5) begin
      errs++;
      $display("FAIL md_count go=%0d bub=%0d exp 1/5", gos, bub);
    end
  endtask

  task automatic test_mem_in_md;
    apply(0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 0, (i == 1), 1, 0, 1, 0);
      checks++;
      if (outv !== e_out || pc_en !== 1'b0 || mem_wb_bubble !== 1'b1) begin
        errs++;
        $display("FAIL memmd_stall%0d out=%b exp=%b", i, outv, e_out);
      end
    end
    apply(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    checks++;
    if (outv !== IDLE_OUT) begin
      errs++;
      $display("FAIL memmd_resume out=%b exp=%b", outv, IDLE_OUT);
    end
  endtask

  task automatic test_trap_md;
    apply(0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    checks++;
    if (outv !== 12'b11111_1110_011) begin
      errs++;
      $display("FAIL trap_md out=%b exp=%b", outv, 12'b111111110011);
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (outv !== IDLE_OUT) begin
      errs++;
      $display("FAIL trap_run out=%b exp=%b", outv, IDLE_OUT);
    end
  endtask

  task automatic test_mispredict_haz;
    apply(0, 1, 1, 1, 0, 0, 0, 0, 1, 0);
    checks++;
    if (if_id_flush !== 1'b0 || pc_en !== 1'b0 || outv !== e_out) begin
      errs++;
      $display("FAIL mp_haz out=%b exp=%b", outv, e_out);
    end
    apply(0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    checks++;
    if (if_id_flush !== 1'b1 || pc_en !== 1'b1) begin
      errs++;
      $display("FAIL mp_alone flush=%b pc_en=%b exp 1/1",
               if_id_flush, pc_en);
    end
    apply(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (outv !== 12'b11111_1000_000) begin
      errs++;
      $display("FAIL mp_imem out=%b exp=%b", outv, 12'b111111000000);
    end
  endtask

  task automatic test_rst_mid;
    apply(0, 1, 2, 0, 0, 0, 0, 0, 1, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (outv !== RST_OUT) begin
      errs++;
      $display("FAIL rst_mid out=%b exp=%b", outv, RST_OUT);
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (outv !== IDLE_OUT) begin
      errs++;
      $display("FAIL rst_after out=%b exp=%b", outv, IDLE_OUT);
    end
`ifdef PIPE_PERF_CNT_EN
    checks++;
    if (stall_cnt !== '0) begin
      errs++;
      $display("FAIL rst_cnt got=%0d exp=0", stall_cnt);
    end
`endif
  endtask

  task automatic test_random;
    bit hold = 0;
    bit tr;
    for (int i = 0; i < 3000; i++) begin
      tr = hold || ($urandom_range(0, 19) == 0);
      apply(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 2)),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 7) != 0),
            tr);
      hold = tr && !e_out[0] && !rst;
      checks++;
      if (outv !== e_out) begin
        errs++;
        $display("FAIL rand%0d out=%b exp=%b", i, outv, e_out);
      end
`ifdef PIPE_PERF_CNT_EN
      checks++;
      if (stall_cnt !== CNT_W'(m_sc) || flush_cnt !== CNT_W'(m_fc)) begin
        errs++;
        $display("FAIL rand_cnt%0d st=%0d fl=%0d exp %0d/%0d",
                 i, stall_cnt, flush_cnt, m_sc, m_fc);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_haz2();
    test_md();
    test_mem_in_md();
    test_trap_md();
    test_mispredict_haz();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
